// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (fetch and data) and the shared memory bus.
// Directions in the names are from the arbiter's point of view.
interface mem_bus_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        stallreq_o;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i,
           mem_wdata_i, bus_rdata_i,
    output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_ce_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, stallreq_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i,
           mem_wdata_i, bus_rdata_i,
    input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_ce_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, stallreq_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one fixed-latency memory bus between the fetch and data ports; data has
// priority but may win at most MEM_BURST grants in a row while fetch is waiting.
module mem_bus_arbiter #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MEM_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  ab
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [3:0] BURST_MAX = 4'(MEM_BURST);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  burst_q, burst_d;
  logic        bus_ce_q, bus_ce_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        grant_mem;

  // Data wins unless fetch is waiting and data has already used its burst allowance.
  assign grant_mem = ab.mem_req_i && !(ab.if_req_i && (burst_q == BURST_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      burst_q     <= '0;
      bus_ce_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    bus_ce_d    = bus_ce_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          gnt_d       = 1'b1;
          bus_ce_d    = 1'b1;
          bus_we_d    = ab.mem_we_i;
          bus_sel_d   = ab.mem_sel_i;
          bus_addr_d  = ab.mem_addr_i;
          bus_wdata_d = ab.mem_wdata_i;
          cnt_d       = CNT_INIT;
          state_d     = S_ACC;
          if (!ab.if_req_i)
            burst_d = '0;
          else if (burst_q != BURST_MAX)
            burst_d = burst_q + 4'd1;
        end else if (ab.if_req_i) begin
          gnt_d       = 1'b0;
          bus_ce_d    = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'b1111;
          bus_addr_d  = ab.if_addr_i;
          bus_wdata_d = '0;
          cnt_d       = CNT_INIT;
          burst_d     = '0;
          state_d     = S_ACC;
        end
      end
      S_ACC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!bus_we_q) begin
            if (gnt_q) mem_rdata_d = ab.bus_rdata_i;
            else       if_rdata_d  = ab.bus_rdata_i;
          end
          bus_ce_d = 1'b0;
          bus_we_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ab.if_ack_o    = (state_q == S_DONE) && !gnt_q;
  assign ab.mem_ack_o   = (state_q == S_DONE) && gnt_q;
  assign ab.if_rdata_o  = if_rdata_q;
  assign ab.mem_rdata_o = mem_rdata_q;
  assign ab.bus_ce_o    = bus_ce_q;
  assign ab.bus_we_o    = bus_we_q;
  assign ab.bus_sel_o   = bus_sel_q;
  assign ab.bus_addr_o  = bus_addr_q;
  assign ab.bus_wdata_o = bus_wdata_q;
  assign ab.stallreq_o  = (ab.if_req_i & ~ab.if_ack_o) | (ab.mem_req_i & ~ab.mem_ack_o);

endmodule
